// File: rtl/ex_wb_if.sv
// Execute-to-writeback bus: upstream result handshake, register-file write port,
// branch redirect and retire counter, bundled so the stage has a single bus port.
interface ex_wb_if;
    logic        _valid;
    logic        ready_;
    logic [31:0] _res;
    logic [2:0]  _sig_op;
    logic        _sig_wb;
    logic [4:0]  _rd;
    logic [31:0] _pc;
    logic [31:0] _imm;
    logic        wb_valid_;
    logic        _wb_ready;
    logic [4:0]  wb_rd_;
    logic [31:0] wb_data_;
    logic        redirect_;
    logic [31:0] redirect_pc_;
    logic [31:0] retired_cnt_;
    logic        _en_trace;

    modport slave (
        input  _valid, _res, _sig_op, _sig_wb, _rd, _pc, _imm, _wb_ready, _en_trace,
        output ready_, wb_valid_, wb_rd_, wb_data_, redirect_, redirect_pc_, retired_cnt_
    );

    modport master (
        output _valid, _res, _sig_op, _sig_wb, _rd, _pc, _imm, _wb_ready, _en_trace,
        input  ready_, wb_valid_, wb_rd_, wb_data_, redirect_, redirect_pc_, retired_cnt_
    );
endinterface

// File: rtl/ex_wb_stage.sv
// Writeback stage: 2-entry (rd, data) FIFO feeding the register-file write port,
// plus one-cycle redirect pulse for taken BEQ/BNE and a commit counter.
module ex_wb_stage (
    input  logic    _clk,
    input  logic    _rst_n,
    ex_wb_if.slave  bus
);

    localparam logic [2:0] OP_BEQ = 3'b010;
    localparam logic [2:0] OP_BNE = 3'b011;

    logic [1:0]  count_q, count_d;
    logic        head_q, head_d;
    logic        tail_q, tail_d;
    logic [4:0]  ent_rd_q [2];
    logic [4:0]  ent_rd_d [2];
    logic [31:0] ent_data_q [2];
    logic [31:0] ent_data_d [2];
    logic        redirect_q, redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [31:0] retired_q, retired_d;

    logic ready;
    logic wb_valid;
    logic is_branch;
    logic accept;
    logic push;
    logic pop;

    // The trace enable only drives simulation-side printing elsewhere.
    logic unused_trace;
    assign unused_trace = bus._en_trace;

    // Ready is gated by reset so it drops the instant reset asserts.
    assign ready    = _rst_n && (count_q != 2'd2);
    assign wb_valid = (count_q != 2'd0);

    always_comb begin
        count_d       = count_q;
        head_d        = head_q;
        tail_d        = tail_q;
        ent_rd_d      = ent_rd_q;
        ent_data_d    = ent_data_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        retired_d     = retired_q;

        is_branch = (bus._sig_op == OP_BEQ) || (bus._sig_op == OP_BNE);
        accept    = bus._valid && ready;
        push      = accept && !is_branch && bus._sig_wb && (bus._rd != 5'd0);
        pop       = wb_valid && bus._wb_ready;

        if (push) begin
            ent_rd_d[tail_q]   = bus._rd;
            ent_data_d[tail_q] = bus._res;
            tail_d             = ~tail_q;
        end

        if (pop) begin
            head_d    = ~head_q;
            retired_d = retired_q + 32'd1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        if (accept && is_branch && bus._res[0]) begin
            redirect_d    = 1'b1;
            redirect_pc_d = bus._pc + bus._imm;
        end
    end

    always_ff @(posedge _clk or negedge _rst_n) begin
        if (!_rst_n) begin
            count_q       <= 2'd0;
            head_q        <= 1'b0;
            tail_q        <= 1'b0;
            ent_rd_q      <= '{default: '0};
            ent_data_q    <= '{default: '0};
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
            retired_q     <= 32'd0;
        end else begin
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            ent_rd_q      <= ent_rd_d;
            ent_data_q    <= ent_data_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            retired_q     <= retired_d;
        end
    end

    assign bus.ready_       = ready;
    assign bus.wb_valid_    = wb_valid;
    assign bus.wb_rd_       = wb_valid ? ent_rd_q[head_q]   : 5'd0;
    assign bus.wb_data_     = wb_valid ? ent_data_q[head_q] : 32'd0;
    assign bus.redirect_    = redirect_q;
    assign bus.redirect_pc_ = redirect_pc_q;
    assign bus.retired_cnt_ = retired_q;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed bench for ex_wb_stage: writeback FIFO ordering, backpressure,
// branch redirects and asynchronous reset, with hand-computed expectations.
module tb_ex_wb_stage;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_BEQ = 3'b010;
    localparam logic [2:0] OP_BNE = 3'b011;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    ex_wb_if bus ();

    ex_wb_stage dut (
        ._clk   (clk),
        ._rst_n (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic wb,
                                 input logic [4:0] rd, input logic [31:0] res,
                                 input logic [31:0] pc, input logic [31:0] imm);
        bus._valid  = v;
        bus._sig_op = op;
        bus._sig_wb = wb;
        bus._rd     = rd;
        bus._res    = res;
        bus._pc     = pc;
        bus._imm    = imm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, OP_ADD, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic checkHead(input string tag, input logic v, input logic [4:0] rd, input logic [31:0] data);
        checkOutput({tag, "_valid"}, {31'd0, bus.wb_valid_}, {31'd0, v});
        checkOutput({tag, "_rd"},    {27'd0, bus.wb_rd_},    {27'd0, rd});
        checkOutput({tag, "_data"},  bus.wb_data_,           data);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus._wb_ready = 1'b0;
        bus._en_trace = 1'b0;
        idle();

        // Reset state
        #2;
        checkOutput("rst_ready",    {31'd0, bus.ready_},    32'd0);
        checkHead("rst_wb", 1'b0, 5'd0, 32'd0);
        checkOutput("rst_redir",    {31'd0, bus.redirect_}, 32'd0);
        checkOutput("rst_redir_pc", bus.redirect_pc_,       32'd0);
        checkOutput("rst_retired",  bus.retired_cnt_,       32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_ready", {31'd0, bus.ready_}, 32'd1);

        // Single ADD write with immediate commit
        bus._wb_ready = 1'b1;
        applyStimulus(1'b1, OP_ADD, 1'b1, 5'd5, 32'h1234, 32'h0, 32'h0);
        tick();
        idle();
        checkHead("add1", 1'b1, 5'd5, 32'h1234);
        tick();
        checkHead("add1_done", 1'b0, 5'd0, 32'd0);
        checkOutput("add1_retired", bus.retired_cnt_, 32'd1);

        // Backpressure: fill both entries, third held upstream
        bus._wb_ready = 1'b0;
        applyStimulus(1'b1, OP_ADD, 1'b1, 5'd1, 32'hA1, 32'h0, 32'h0);
        tick();
        applyStimulus(1'b1, OP_SUB, 1'b1, 5'd2, 32'hA2, 32'h0, 32'h0);
        tick();
        checkOutput("full_ready", {31'd0, bus.ready_}, 32'd0);
        applyStimulus(1'b1, OP_ADD, 1'b1, 5'd3, 32'hA3, 32'h0, 32'h0);
        tick();
        tick();
        checkOutput("held_ready", {31'd0, bus.ready_}, 32'd0);
        checkHead("held_head", 1'b1, 5'd1, 32'hA1);
        bus._wb_ready = 1'b1;
        tick();
        checkHead("pop1", 1'b1, 5'd2, 32'hA2);
        checkOutput("pop1_ready", {31'd0, bus.ready_}, 32'd1);
        checkOutput("pop1_retired", bus.retired_cnt_, 32'd2);
        // count=1 with push and pop on the same edge
        tick();
        idle();
        checkHead("pushpop", 1'b1, 5'd3, 32'hA3);
        checkOutput("pushpop_retired", bus.retired_cnt_, 32'd3);
        tick();
        checkHead("drain", 1'b0, 5'd0, 32'd0);
        checkOutput("drain_retired", bus.retired_cnt_, 32'd4);

        // Writes to x0 and non-writing ops are dropped
        applyStimulus(1'b1, OP_ADD, 1'b1, 5'd0, 32'h55, 32'h0, 32'h0);
        tick();
        applyStimulus(1'b1, OP_SUB, 1'b0, 5'd7, 32'h66, 32'h0, 32'h0);
        tick();
        idle();
        checkOutput("nowr_valid", {31'd0, bus.wb_valid_}, 32'd0);
        tick();
        checkOutput("nowr_retired", bus.retired_cnt_, 32'd4);

        // Branches: taken BEQ, not-taken BNE, back-to-back taken
        applyStimulus(1'b1, OP_BEQ, 1'b1, 5'd9, 32'h1, 32'h100, 32'hFFFF_FFF0);
        tick();
        checkOutput("beq_redir",    {31'd0, bus.redirect_},  32'd1);
        checkOutput("beq_pc",       bus.redirect_pc_,        32'h0F0);
        checkOutput("beq_nowrite",  {31'd0, bus.wb_valid_}, 32'd0);
        applyStimulus(1'b1, OP_BNE, 1'b0, 5'd0, 32'h0, 32'h200, 32'h4);
        tick();
        checkOutput("bne_nt_redir", {31'd0, bus.redirect_}, 32'd0);
        checkOutput("bne_nt_pc",    bus.redirect_pc_,       32'h0F0);
        applyStimulus(1'b1, OP_BNE, 1'b0, 5'd0, 32'h3, 32'h1000, 32'h10);
        tick();
        checkOutput("b2b1_redir", {31'd0, bus.redirect_}, 32'd1);
        checkOutput("b2b1_pc",    bus.redirect_pc_,       32'h1010);
        applyStimulus(1'b1, OP_BEQ, 1'b0, 5'd0, 32'h1, 32'hFFFF_FFF0, 32'h20);
        tick();
        idle();
        checkOutput("b2b2_redir", {31'd0, bus.redirect_}, 32'd1);
        checkOutput("b2b2_pc",    bus.redirect_pc_,       32'h10);
        tick();
        checkOutput("b2b_end",    {31'd0, bus.redirect_}, 32'd0);

        // Redirect does not flush a buffered write
        bus._wb_ready = 1'b0;
        applyStimulus(1'b1, OP_ADD, 1'b1, 5'd4, 32'h44, 32'h0, 32'h0);
        tick();
        applyStimulus(1'b1, OP_BEQ, 1'b0, 5'd0, 32'h1, 32'h300, 32'h8);
        tick();
        idle();
        checkOutput("mix_redir", {31'd0, bus.redirect_}, 32'd1);
        checkOutput("mix_pc",    bus.redirect_pc_,       32'h308);
        checkHead("mix_head", 1'b1, 5'd4, 32'h44);
        applyStimulus(1'b1, OP_ADD, 1'b1, 5'd6, 32'h66, 32'h0, 32'h0);
        tick();
        idle();
        checkOutput("mix_full", {31'd0, bus.ready_}, 32'd0);

        // Asynchronous reset mid-cycle with two entries buffered
        applyStimulus(1'b1, OP_BNE, 1'b0, 5'd0, 32'h1, 32'h400, 32'h4);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_ready",    {31'd0, bus.ready_},    32'd0);
        checkHead("arst_wb", 1'b0, 5'd0, 32'd0);
        checkOutput("arst_redir",    {31'd0, bus.redirect_}, 32'd0);
        checkOutput("arst_redir_pc", bus.redirect_pc_,       32'd0);
        checkOutput("arst_retired",  bus.retired_cnt_,       32'd0);
        idle();
        bus._wb_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("rel_ready", {31'd0, bus.ready_}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rel_wb_valid", {31'd0, bus.wb_valid_}, 32'd0);
            checkOutput("rel_redir",    {31'd0, bus.redirect_}, 32'd0);
            checkOutput("rel_retired",  bus.retired_cnt_,       32'd0);
        end

        // Normal operation resumes after reset
        applyStimulus(1'b1, OP_ADD, 1'b1, 5'd31, 32'hDEAD_BEEF, 32'h0, 32'h0);
        tick();
        idle();
        checkHead("resume", 1'b1, 5'd31, 32'hDEAD_BEEF);
        tick();
        checkOutput("resume_retired", bus.retired_cnt_, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_wb_stage.md
EX_WB_STAGE -- requirements
Module: ex_wb_stage

Interface
REQ-001 _clk  input  1  single clock; all state updates on rising edge.
REQ-002 _rst_n  input  1  asynchronous, active-low reset.
REQ-003 _valid  input  1  executor result valid this cycle.
REQ-004 ready_  output  1  stage can accept a result this cycle.
REQ-005 _res  input  32  ALU result from execute stage.
REQ-006 _sig_op  input  3  ALU op, Decoder.v encodings (ADD, SUB, BEQ, BNE).
REQ-007 _sig_wb  input  1  instruction writes rd.
REQ-008 _rd  input  5  destination register index.
REQ-009 _pc  input  32  PC of the instruction.
REQ-010 _imm  input  32  immediate; branch offset for BEQ/BNE.
REQ-011 wb_valid_  output  1  register-file write request pending.
REQ-012 _wb_ready  input  1  register-file write port grants this cycle.
REQ-013 wb_rd_  output  5  write index (head entry).
REQ-014 wb_data_  output  32  write data (head entry).
REQ-015 redirect_  output  1  one-cycle pulse: taken branch resolved.
REQ-016 redirect_pc_  output  32  branch target, valid while redirect_=1.
REQ-017 retired_cnt_  output  32  count of committed register writes.
REQ-018 _en_trace  input  1  enables simulation-only trace print per commit; no effect on RTL behaviour.

Function
REQ-019 Writeback buffer SHALL be a 2-entry FIFO (rd, data) with 1-bit head/tail pointers and a 2-bit count (0..2).
REQ-020 ready_ SHALL be 1 iff _rst_n=1 and count<2; ready_ SHALL not depend combinationally on _wb_ready.
REQ-021 Accept occurs when _valid=1 and ready_=1; when _valid=1 and ready_=0, inputs SHALL be ignored and upstream holds them.
REQ-022 Accepted non-branch op with _sig_wb=1 and _rd!=0 SHALL be enqueued at tail, visible at the output one cycle later at the earliest.
REQ-023 Accepted entries with _sig_wb=0, _rd=0, or op BEQ/BNE SHALL NOT be enqueued.
REQ-024 wb_valid_ SHALL equal (count!=0); wb_rd_/wb_data_ SHALL reflect the head entry and hold stable while wb_valid_=1 and _wb_ready=0.
REQ-025 Pop occurs when wb_valid_=1 and _wb_ready=1; head advances, retired_cnt_ increments by 1 (wraps modulo 2^32).
REQ-026 Simultaneous push and pop SHALL leave count unchanged; push when full is impossible (ready_=0) even if a pop occurs that cycle.
REQ-027 Pointers SHALL wrap 1->0; FIFO order SHALL be strictly preserved.
REQ-028 Accepted BEQ/BNE with _res[0]=1 SHALL set redirect_=1 for exactly the next cycle with redirect_pc_ = (_pc + _imm) mod 2^32.
REQ-029 Accepted BEQ/BNE with _res[0]=0 SHALL leave redirect_=0 next cycle; redirect_pc_ SHALL hold its last value.
REQ-030 Taken branches on consecutive accept cycles SHALL produce redirect_ high on consecutive cycles, each with its own target.
REQ-031 Redirect SHALL not flush or modify buffered writes; older writes still commit.
REQ-032 When wb_valid_=0, wb_rd_ and wb_data_ SHALL be 0.

Reset
REQ-033 _rst_n=0 SHALL immediately, without a clock edge, force count=0, pointers=0, wb_valid_=0, ready_=0, redirect_=0, redirect_pc_=0, retired_cnt_=0, wb_rd_=0, wb_data_=0.
REQ-034 Reset mid-operation SHALL discard all buffered entries and any pending redirect; no write or redirect SHALL be issued for them after reset.
REQ-035 ready_=1 from the first cycle with _rst_n=1.

Verification
REQ-036 ADD, rd=5, res=0x1234, _wb_ready=1 -> next cycle wb_valid_=1, wb_rd_=5, wb_data_=0x1234; following cycle wb_valid_=0, retired_cnt_=1.
REQ-037 _wb_ready=0, three valid writes rd=1,2,3 -> after two accepts ready_=0, rd=3 held upstream; raise _wb_ready -> commits strictly in order 1,2,3, retired_cnt_=3.
REQ-038 BEQ res=1, pc=0x100, imm=0xFFFFFFF0 -> redirect_=1 one cycle, redirect_pc_=0x0F0, no write; BNE res=0 -> redirect_=0.
REQ-039 FIFO count=1 with push and pop same cycle -> count stays 1, data order preserved; ADD rd=0 -> no write issued.
REQ-040 Two entries buffered plus redirect pending, assert _rst_n=0 between edges -> outputs 0 immediately; after release no write and no redirect appear.
